// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural NVZ flags, branch resolution and halt control for the execute stage
module flag_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [3:0]  opcode,
  input  logic [2:0]  alu_flags,
  input  logic [2:0]  ccc,
  input  logic [15:0] pc_plus2,
  input  logic [8:0]  imm9,
  input  logic [15:0] rs_val,
  input  logic        stall,
  output logic [2:0]  flags,
  output logic        br_taken,
  output logic [15:0] br_target,
  output logic        flush,
  output logic        halt
);
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
  state_t state, state_nx;
  logic acc, taken_nx;
  logic [2:0] flags_nx;
  logic [7:0] conds;
  logic [15:0] target_nx, b_tgt;
  assign halt = state == HALTED;
  always_comb begin
    acc = ex_valid && !stall && state == RUN;
    flags_nx = flags;
    if (acc && opcode inside {4'b0000, 4'b0001}) flags_nx = alu_flags;
    else if (acc && opcode inside {4'b0010, 4'b0100, 4'b0101, 4'b0110}) flags_nx = {flags[2:1], alu_flags[0]};
    // conditions use the bypassed flags, indexed by ccc
    conds = {1'b1, flags_nx[1], flags_nx[2] | flags_nx[0], flags_nx[0] | ~flags_nx[2],
             flags_nx[2], ~flags_nx[0] & ~flags_nx[2], flags_nx[0], ~flags_nx[0]};
    b_tgt = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
    taken_nx = acc && (opcode == 4'b1100 || opcode == 4'b1101) && conds[ccc];
    target_nx = taken_nx ? (opcode[0] ? rs_val : b_tgt) : br_target;
    state_nx = stall ? state :
               state == HALTED ? HALTED :
               state == FLUSH ? RUN :
               (acc && opcode == 4'b1111) ? HALTED :
               taken_nx ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      flags <= 3'b000;
      br_taken <= 1'b0;
      flush <= 1'b0;
      br_target <= 16'h0000;
    end else begin
      state <= state_nx;
      flags <= flags_nx;
      br_taken <= taken_nx;
      flush <= taken_nx;
      br_target <= target_nx;
    end
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed scenarios plus randomized traffic checked against a behavioural model
module tb_flag_branch_unit;
  logic clk = 0, rst_n = 0, ex_valid = 0, stall = 0;
  logic [3:0] opcode = 0;
  logic [2:0] alu_flags = 0, ccc = 0;
  logic [15:0] pc_plus2 = 0, rs_val = 0;
  logic [8:0] imm9 = 0;
  logic [2:0] flags;
  logic br_taken, flush, halt;
  logic [15:0] br_target;
  int n_checks = 0, n_pass = 0;
  logic [2:0] m_flags;
  int m_mode;
  logic m_taken;
  logic [15:0] m_target;
  logic [15:0] saved_t;
  logic [2:0] saved_f;

  flag_branch_unit dut (.clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .opcode(opcode),
    .alu_flags(alu_flags), .ccc(ccc), .pc_plus2(pc_plus2), .imm9(imm9), .rs_val(rs_val),
    .stall(stall), .flags(flags), .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .halt(halt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_flags = 0; m_mode = 0; m_taken = 0; m_target = 0;
  endtask

  task automatic model_step();
    logic n, v, z, c;
    m_taken = 0;
    if (stall || m_mode == 2) return;
    if (m_mode == 1) begin m_mode = 0; return; end
    if (!ex_valid) return;
    case (opcode)
      0, 1: m_flags = alu_flags;
      2, 4, 5, 6: m_flags[0] = alu_flags[0];
      default: ;
    endcase
    {n, v, z} = m_flags;
    if (opcode == 15) m_mode = 2;
    if (opcode == 12 || opcode == 13) begin
      case (ccc)
        0: c = !z;
        1: c = z;
        2: c = !z && !n;
        3: c = n;
        4: c = z || (!z && !n);
        5: c = n || z;
        6: c = v;
        default: c = 1;
      endcase
      if (c) begin
        m_taken = 1;
        m_mode = 1;
        m_target = opcode == 12 ? 16'((int'(pc_plus2) + 2 * int'($signed(imm9))) & 32'hFFFF) : rs_val;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'(m_flags));
    check({tag, ".br_taken"}, 32'(br_taken), 32'(m_taken));
    check({tag, ".flush"}, 32'(flush), 32'(m_taken));
    check({tag, ".br_target"}, 32'(br_target), 32'(m_target));
    check({tag, ".halt"}, 32'(halt), 32'(m_mode == 2));
  endtask

  task automatic cyc(input string tag, input logic v, input logic [3:0] op, input logic [2:0] af,
                     input logic [2:0] cc, input logic [15:0] pc, input logic [8:0] imm,
                     input logic [15:0] rs, input logic st);
    ex_valid = v; opcode = op; alu_flags = af; ccc = cc; pc_plus2 = pc; imm9 = imm; rs_val = rs; stall = st;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    // SUB sets Z, B EQ taken with offset target
    cyc("s35_sub", 1, 4'h1, 3'b001, 0, 0, 0, 0, 0);
    cyc("s35_b", 1, 4'hC, 3'b000, 3'b001, 16'h0010, 9'h003, 0, 0);
    check("s35_target", 32'(br_target), 32'h0016);
    check("s35_taken", 32'(br_taken), 32'h1);
    check("s35_flags", 32'(flags), 32'h1);
    cyc("s35_after", 0, 0, 0, 0, 0, 0, 0, 0);
    check("s35_flush_1cyc", 32'(flush), 32'h0);
    // ADD then BR on V, then a flush slot, then XOR updates Z only
    cyc("s36_add", 1, 4'h0, 3'b110, 0, 0, 0, 0, 0);
    cyc("s36_br", 1, 4'hD, 0, 3'b110, 0, 0, 16'h1234, 0);
    check("s36_br_taken", 32'(br_taken), 32'h1);
    check("s36_br_target", 32'(br_target), 32'h1234);
    cyc("s36_flush", 1, 4'h0, 3'b000, 0, 0, 0, 0, 0);
    cyc("s36_xor", 1, 4'h2, 3'b001, 0, 0, 0, 0, 0);
    check("s36_flags", 32'(flags), 32'h7);
    // wrap-around target; ADD in FLUSH ignored
    cyc("s37_b", 1, 4'hC, 0, 3'b111, 16'hFFFE, 9'h001, 0, 0);
    check("s37_target", 32'(br_target), 32'h0000);
    saved_f = flags;
    cyc("s37_add", 1, 4'h0, 3'b010, 0, 0, 0, 0, 0);
    check("s37_flags_held", 32'(flags), 32'(saved_f));
    // NE with Z=1 is not taken
    cyc("s38_sub", 1, 4'h1, 3'b001, 0, 0, 0, 0, 0);
    saved_t = br_target;
    cyc("s38_b", 1, 4'hC, 0, 3'b000, 16'h0100, 9'h010, 0, 0);
    check("s38_taken", 32'(br_taken), 32'h0);
    check("s38_target", 32'(br_target), 32'(saved_t));
    // stall blocks a taken branch until released
    cyc("s40_stall", 1, 4'hC, 0, 3'b111, 16'h0200, 9'h1FF, 0, 1);
    check("s40_stalled", 32'(br_taken), 32'h0);
    cyc("s40_go", 1, 4'hC, 0, 3'b111, 16'h0200, 9'h1FF, 0, 0);
    check("s40_taken", 32'(br_taken), 32'h1);
    check("s40_target", 32'(br_target), 32'h01FE);
    cyc("s40_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    // HLT is sticky; async reset clears outputs before the next edge
    cyc("s39_add", 1, 4'h0, 3'b100, 0, 0, 0, 0, 0);
    cyc("s39_hlt", 1, 4'hF, 0, 0, 0, 0, 0, 0);
    check("s39_halt", 32'(halt), 32'h1);
    for (int i = 0; i < 5; i++)
      cyc("s39_held", 1, i[0] ? 4'hC : 4'h0, 3'b011, 3'b111, 16'h0040, 9'h004, 0, 0);
    check("s39_sticky", 32'(halt), 32'h1);
    check("s39_frozen", 32'(flags), 32'h4);
    do_reset();
    check("s39_reset_halt", 32'(halt), 32'h0);
    // randomized traffic, with periodic resets to leave HALTED
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 120; i++) begin
        logic [3:0] op;
        op = 4'($urandom);
        if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'hC;
        cyc("rand", $urandom_range(0, 9) < 8, op, 3'($urandom), 3'($urandom), 16'($urandom),
            9'($urandom), 16'($urandom), $urandom_range(0, 6) == 0);
      end
      do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: ex_valid  in  1  ALU result/instruction in execute is valid this cycle.
REQ-004 SHALL have ports: opcode  in  4  execute-stage opcode (0000 ADD ... 1111 HLT).
REQ-005 SHALL have ports: alu_flags  in  3  {N,V,Z} from the ALU for this instruction.
REQ-006 SHALL have ports: ccc  in  3  branch condition code.
REQ-007 SHALL have ports: pc_plus2  in  16  address of the next sequential instruction.
REQ-008 SHALL have ports: imm9  in  9  signed B offset, in halfwords.
REQ-009 SHALL have ports: rs_val  in  16  BR register target.
REQ-010 SHALL have ports: stall  in  1  pipeline hold; freezes all state.
REQ-011 SHALL have ports: flags  out  3  architectural {N,V,Z}, registered.
REQ-012 SHALL have ports: br_taken  out  1  registered; branch resolved taken.
REQ-013 SHALL have ports: br_target  out  16  registered redirect address; valid when br_taken=1.
REQ-014 SHALL have ports: flush  out  1  registered; squash the wrong-path instruction.
REQ-015 SHALL have ports: halt  out  1  registered, sticky halt indication.

Function
REQ-016 SHALL implement FSM states RUN, FLUSH, HALTED.
REQ-017 SHALL treat an instruction as accepted only when ex_valid=1, stall=0, and the state is RUN.
REQ-018 SHALL update flag bits for accepted ADD(0000) and SUB(0001) as N, V, Z <- alu_flags.
REQ-019 SHALL update only Z for accepted XOR(0010), SLL(0100), SRA(0101), and ROR(0110), holding N and V.
REQ-020 SHALL leave flags unchanged for all other opcodes.
REQ-021 SHALL evaluate the condition for accepted B(1100) and BR(1101) against bypassed flags (the value flags will take at the end of this cycle), not the stale register.
REQ-022 SHALL decode ccc as: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GE Z=1|(Z=0&N=0); 101 LE N=1|Z=1; 110 OV V=1; 111 always.
REQ-023 SHALL compute the B target as pc_plus2 + (sign-extended imm9 << 1), mod 2^16, with wrap-around permitted.
REQ-024 SHALL use rs_val unmodified as the BR target.
REQ-025 SHALL, on a taken branch, assert br_taken and flush for exactly one cycle on the next edge, load br_target, and move to FLUSH.
REQ-026 SHALL, on a not-taken branch, keep br_taken=0 with br_target holding its previous value.
REQ-027 SHALL, in FLUSH, ignore ex_valid (no flag update, no branch, no halt), then return to RUN on the next non-stalled edge.
REQ-028 SHALL, on accepted HLT(1111), enter HALTED with halt=1 from the next edge.
REQ-029 SHALL ignore all inputs in HALTED and leave HALTED only on reset.
REQ-030 SHALL, with stall=1, hold state, flags, br_target, and halt, and force br_taken=0 and flush=0 on that edge.
REQ-031 SHALL deassert br_taken and flush one cycle after assertion whenever they are not re-asserted.
REQ-032 SHALL have an evaluation latency of 1 cycle from an accepted branch to br_taken/flush.

Reset
REQ-033 SHALL, when rst_n=0 at any time (including in FLUSH or HALTED), immediately force state=RUN, flags=000, br_taken=0, br_target=0x0000, flush=0, halt=0.
REQ-034 SHALL use no reset synchronizer internally, with deassertion aligned by the system.

Verification
REQ-035 SHALL pass this scenario: SUB with alu_flags=001, then B ccc=001 pc_plus2=0x0010 imm9=0x003 -> br_taken=1, br_target=0x0016, flush=1 for one cycle, flags=001.
REQ-036 SHALL pass this scenario: accepted ADD alu_flags=110 and BR ccc=110 on consecutive cycles, then XOR alu_flags=001 -> flags=111 after XOR, V bypass proven by BR taken.
REQ-037 SHALL pass this scenario: B ccc=111 pc_plus2=0xFFFE imm9=0x001 -> br_target=0x0000; the following ADD in FLUSH is ignored (flags unchanged).
REQ-038 SHALL pass this scenario: B ccc=000 with Z=1 -> br_taken=0, flush=0, br_target unchanged.
REQ-039 SHALL pass this scenario: HLT accepted, then ADD/B held valid for 5 cycles -> halt=1 sticky, flags frozen; rst_n low mid-cycle -> all outputs 0 before the next edge.
REQ-040 SHALL pass this scenario: stall=1 coincident with taken B -> no br_taken; stall released with same inputs -> br_taken=1 next edge.
